div_int: RTL and testbench

//   Sequential unsigned integer divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient + remainder.

---
 rtl/div_int_pkg.sv | 21 ++
 rtl/div_int_if.sv | 29 ++
 rtl/div_int_step.sv | 22 ++
 rtl/div_int.sv | 152 +++++++++++++++
 tb/tb_div_int.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_int_pkg.sv
// Shared types and constants for the sequential integer divider.
// No logic here; latency and handshake behaviour live in div_int.
package div_int_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  // Quotient reported on divide-by-zero is all ones, built by replication.
  localparam logic DBZ_QUO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_int_if.sv
// Start/done handshake between the ALU issue stage and the divider.
// The sgn request bit exists only when DIV_INT_SIGNED_EN is defined.
interface div_int_if
  import div_int_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIV_INT_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;

`ifdef DIV_INT_SIGNED_EN
  modport master (output start, a, b, sgn, input busy, done, q, r, dbz);
  modport slave  (input start, a, b, sgn, output busy, done, q, r, dbz);
`else
  modport master (output start, a, b, input busy, done, q, r, dbz);
  modport slave  (input start, a, b, output busy, done, q, r, dbz);
`endif

endinterface

// File: rtl/div_int_step.sv
// One restoring-division stage: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the borrow of the WIDTH+1-bit difference decides the quotient bit.
module div_int_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so trial < 2*divisor and the difference never overflows.
  assign trial   = {rem_in, quo_msb};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_int.sv
// Sequential restoring divider, one quotient bit per clock; DIV_INT_SIGNED_EN adds signed ops.
// Done pulses WIDTH cycles after accept (+1 signed, 0 on b==0); start ignored while busy.
module div_int
  import div_int_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input logic      clk,
  input logic      rst_n,
  div_int_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             fix_req;
  logic             b_zero;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_nxt;

`ifdef DIV_INT_SIGNED_EN
  logic sgn_op;
  logic neg_q;
  logic neg_r;

  // Signed operands run through the unsigned core as magnitudes.
  assign a_op    = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_op    = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign fix_req = sgn_op;
`else
  assign a_op    = bus.a;
  assign b_op    = bus.b;
  assign fix_req = 1'b0;
`endif

  assign b_zero  = (bus.b == '0);
  assign quo_nxt = {quo[WIDTH-2:0], step_q};

  div_int_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .quo_msb (quo[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = b_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nxt = fix_req ? FIX : DONE;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
`ifdef DIV_INT_SIGNED_EN
      sgn_op  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt <= CW'(WIDTH - 1);
            rem <= '0;
            quo <= a_op;
            dvs <= b_op;
`ifdef DIV_INT_SIGNED_EN
            sgn_op <= bus.sgn && !b_zero;
            neg_q  <= bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= bus.sgn && bus.a[WIDTH-1];
`endif
            if (b_zero) begin
              q_reg   <= {WIDTH{DBZ_QUO_FILL}};
              r_reg   <= bus.a;
              dbz_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= step_rem;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if ((cnt == '0) && !fix_req) begin
            q_reg   <= quo_nxt;
            r_reg   <= step_rem;
            dbz_reg <= 1'b0;
          end
        end
        FIX: begin
`ifdef DIV_INT_SIGNED_EN
          // Truncation toward zero: remainder follows the dividend's sign.
          q_reg   <= neg_q ? -quo : quo;
          r_reg   <= neg_r ? -rem : rem;
          dbz_reg <= 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.dbz  = dbz_reg;

endmodule

// File: tb/tb_div_int.sv
// Scoreboarded bench for div_int: driver pushes model results, a negedge monitor pops on done.
// Checks values, dbz flag, done latency, busy behaviour, ignored starts and async reset abort.
module tb_div_int;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   n_push = 0;
  int   n_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  div_int_if #(.WIDTH(W)) bus ();

  div_int #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic, k is the accepting clock edge number.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic s, input int k);
    exp_t e;
    int signed sa;
    int signed sbv;
    e.dbz = 1'b0;
    e.due = k + W;
    if (bv == '0) begin
      e.q   = '1;
      e.r   = av;
      e.dbz = 1'b1;
      e.due = k;
    end else if (!s) begin
      e.q = av / bv;
      e.r = av % bv;
    end else begin
      e.due = k + W + 1;
      sa    = av;
      sbv   = bv;
      if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = '0;
      end else begin
        e.q = sa / sbv;
        e.r = sa % sbv;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      tests++;
      n_done++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with q=%h r=%h at cycle %0d, want no done",
                 bus.q, bus.r, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.q !== mon_e.q || bus.r !== mon_e.r || bus.dbz !== mon_e.dbz || cyc != mon_e.due) begin
          fails++;
          $display("FAIL result: got q=%h r=%h dbz=%b cycle=%0d, want q=%h r=%h dbz=%b cycle=%0d",
                   bus.q, bus.r, bus.dbz, cyc, mon_e.q, mon_e.r, mon_e.dbz, mon_e.due);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input bit push);
    logic se;
    @(negedge clk);
    chk("idle_busy", W'(bus.busy), W'(0));
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
`ifdef DIV_INT_SIGNED_EN
    bus.sgn = s;
    se      = s;
`else
    se      = 1'b0 & s;
`endif
    if (push) begin
      sb.push_back(model(av, bv, se, cyc + 1));
      n_push++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    bit busy_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("done_seen", W'(bus.done), W'(1));
    chk("busy_during_op", W'(busy_ok), W'(1));
  endtask

  task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    issue(av, bv, s, 1'b1);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int sel;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef DIV_INT_SIGNED_EN
    bus.sgn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_q", bus.q, W'(0));
    chk("rst_r", bus.r, W'(0));
    chk("rst_dbz", W'(bus.dbz), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    rst_n = 1'b1;

    run(32'd100, 32'd7, 1'b0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(32'd5, 32'd0, 1'b0);
    run(32'd6, 32'd3, 1'b0);

    // Starts during RUN and during DONE must be ignored.
    issue(32'd1234567, 32'd89, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    bus.a     = 32'd3;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignored_busy", W'(bus.busy), W'(0));
    chk("ignored_done", W'(bus.done), W'(0));
    chk("held_q", bus.q, W'(1234567 / 89));
    repeat (40) @(negedge clk);
    chk("held_r", bus.r, W'(1234567 % 89));

    // Abort mid-operation.
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q", bus.q, W'(0));
    chk("abort_r", bus.r, W'(0));
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_done", W'(bus.done), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(32'd9, 32'd4, 1'b0);

`ifdef DIV_INT_SIGNED_EN
    run(-32'sd7, 32'sd2, 1'b1);
    run(32'sd7, -32'sd2, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(-32'sd7, 32'd0, 1'b1);
    run(32'hFFFF_FFF9, 32'd2, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 15);
      ra  = (sel < 4) ? W'($urandom_range(0, 1000)) : W'($urandom);
      if (sel == 0)      rb = '0;
      else if (sel < 7)  rb = W'($urandom_range(1, 20));
      else               rb = W'($urandom);
      run(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (40) @(negedge clk);
    chk("queue_empty", W'(sb.size()), W'(0));
    chk("done_count", W'(n_done), W'(n_push));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
